// File: rtl/sv_video_pkg.sv
// rtl/sv_video_pkg.sv - shared video types, default palette and frame geometry
package sv_video_pkg;

  // 160x160 LCD, one history entry per active pixel
  localparam int SV_PIX_COUNT = 160 * 160;

  typedef struct packed {
    logic [7:0] r;
    logic [7:0] g;
    logic [7:0] b;
  } rgb_t;

  // Entry 0 occupies the least significant 24 bits
  typedef rgb_t [3:0] palette_t;

  localparam palette_t DEFAULT_PALETTE = {
    24'h384052,
    24'h386B82,
    24'h6BA378,
    24'h87BA6B
  };

endpackage

// File: rtl/sv_pixel_ram.sv
// rtl/sv_pixel_ram.sv - single-clock simple dual-port RAM, read-old-data
module sv_pixel_ram #(
  parameter int WIDTH  = 2,
  parameter int ADDR_W = 15,
  parameter int DEPTH  = 1 << ADDR_W
) (
  input  logic              clk_sys,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [WIDTH-1:0]  wdata,
  input  logic              re,
  input  logic [ADDR_W-1:0] raddr,
  output logic [WIDTH-1:0]  q
);

  logic [WIDTH-1:0] mem [DEPTH];

  // Write and registered read share the edge, so a same-address read returns the old word
  always_ff @(posedge clk_sys) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
    if (re) begin
      q <= mem[raddr];
    end
  end

endmodule

// File: rtl/sv_frame_blender.sv
// rtl/sv_frame_blender.sv - palette mapping and 50/50 temporal blend with one-frame history
module sv_frame_blender
  import sv_video_pkg::*;
#(
  parameter int PIX_COUNT = SV_PIX_COUNT,
  parameter int ADDR_W    = 15
) (
  input  logic       clk_sys,
  input  logic       reset,
  input  logic       ce_pix,
  input  logic [1:0] pixel,
  input  logic       hsync,
  input  logic       vsync,
  input  logic       hblank,
  input  logic       vblank,
  input  logic       blend_en,
  input  logic       custom_pal_en,
  input  logic       pal_wr,
  input  logic [3:0] pal_addr,
  input  logic [7:0] pal_din,
  output logic [7:0] red,
  output logic [7:0] green,
  output logic [7:0] blue,
  output logic       hsync_out,
  output logic       vsync_out,
  output logic       hblank_out,
  output logic       vblank_out
);

  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(PIX_COUNT - 1);

  logic              active;
  logic              ram_we;
  logic [ADDR_W-1:0] addr_cnt;
  logic              ovf;
  logic              seen_active;
  logic              frame_valid;
  logic [1:0]        ram_q;

  logic [1:0]        s1_pix;
  logic              s1_hsync;
  logic              s1_vsync;
  logic              s1_hblank;
  logic              s1_vblank;
  logic              s1_blend;

  palette_t          user_pal;
  palette_t          cur_pal;
  logic [1:0]        wr_entry;
  logic [1:0]        wr_byte;
  logic [1:0]        prev_idx;
  rgb_t              c_cur;
  rgb_t              c_prev;
  rgb_t              c_mix;

  // Truncating average of two channel values via a 9-bit sum
  function automatic logic [7:0] avg8(input logic [7:0] a, input logic [7:0] b);
    logic [8:0] sum;
    sum = {1'b0, a} + {1'b0, b};
    return sum[8:1];
  endfunction

  // vsync is excluded so a pixel coinciding with the frame restart is never stored
  assign active = ce_pix & ~hblank & ~vblank & ~vsync;
  // Once the counter has saturated, history is frozen for the rest of the frame
  assign ram_we = active & ~ovf;

  // Frame address counter, overflow flag and history validity tracking
  always_ff @(posedge clk_sys or posedge reset) begin
    if (reset) begin
      addr_cnt    <= '0;
      ovf         <= 1'b0;
      seen_active <= 1'b0;
      frame_valid <= 1'b0;
    end else if (ce_pix) begin
      if (vsync) begin
        addr_cnt    <= '0;
        ovf         <= 1'b0;
        seen_active <= 1'b0;
        if (seen_active) begin
          frame_valid <= 1'b1;
        end
      end else if (active) begin
        seen_active <= 1'b1;
        if (!ovf) begin
          if (addr_cnt == LAST_ADDR) begin
            ovf <= 1'b1;
          end else begin
            addr_cnt <= addr_cnt + ADDR_W'(1);
          end
        end
      end
    end
  end

  sv_pixel_ram #(
    .WIDTH  (2),
    .ADDR_W (ADDR_W),
    .DEPTH  (1 << ADDR_W)
  ) u_history (
    .clk_sys (clk_sys),
    .we      (ram_we),
    .waddr   (addr_cnt),
    .wdata   (pixel),
    .re      (ram_we),
    .raddr   (addr_cnt),
    .q       (ram_q)
  );

  // Stage 1: capture pixel, timing and whether the RAM read is a usable previous pixel
  always_ff @(posedge clk_sys or posedge reset) begin
    if (reset) begin
      s1_pix    <= 2'd0;
      s1_hsync  <= 1'b0;
      s1_vsync  <= 1'b0;
      s1_hblank <= 1'b1;
      s1_vblank <= 1'b1;
      s1_blend  <= 1'b0;
    end else if (ce_pix) begin
      s1_pix    <= pixel;
      s1_hsync  <= hsync;
      s1_vsync  <= vsync;
      s1_hblank <= hblank;
      s1_vblank <= vblank;
      s1_blend  <= ram_we & frame_valid;
    end
  end

  assign wr_entry = 2'(pal_addr / 4'd3);
  assign wr_byte  = 2'(pal_addr % 4'd3);

  // User palette bytes, R/G/B per entry; addresses 12..15 do not map to any entry
  always_ff @(posedge clk_sys or posedge reset) begin
    if (reset) begin
      user_pal <= DEFAULT_PALETTE;
    end else if (pal_wr && (pal_addr < 4'd12)) begin
      case (wr_byte)
        2'd0:    user_pal[wr_entry].r <= pal_din;
        2'd1:    user_pal[wr_entry].g <= pal_din;
        default: user_pal[wr_entry].b <= pal_din;
      endcase
    end
  end

  // Stage 2 datapath: palette lookup of current and previous pixel, optional blend
  always_comb begin
    cur_pal  = custom_pal_en ? user_pal : DEFAULT_PALETTE;
    prev_idx = s1_blend ? ram_q : s1_pix;
    c_cur    = cur_pal[s1_pix];
    c_prev   = cur_pal[prev_idx];
    c_mix    = c_cur;
    if (blend_en) begin
      c_mix.r = avg8(c_cur.r, c_prev.r);
      c_mix.g = avg8(c_cur.g, c_prev.g);
      c_mix.b = avg8(c_cur.b, c_prev.b);
    end
  end

  // Stage 2: register colour and delayed timing together so they stay aligned
  always_ff @(posedge clk_sys or posedge reset) begin
    if (reset) begin
      red        <= 8'd0;
      green      <= 8'd0;
      blue       <= 8'd0;
      hsync_out  <= 1'b0;
      vsync_out  <= 1'b0;
      hblank_out <= 1'b1;
      vblank_out <= 1'b1;
    end else if (ce_pix) begin
      red        <= c_mix.r;
      green      <= c_mix.g;
      blue       <= c_mix.b;
      hsync_out  <= s1_hsync;
      vsync_out  <= s1_vsync;
      hblank_out <= s1_hblank;
      vblank_out <= s1_vblank;
    end
  end

endmodule

// File: tb/tb_sv_frame_blender.sv
// tb/tb_sv_frame_blender.sv - self-checking bench for sv_frame_blender
module tb_sv_frame_blender;

  logic       clk_sys = 1'b0;
  logic       reset = 1'b1;
  logic       ce_pix = 1'b0;
  logic [1:0] pixel = 2'd0;
  logic       hsync = 1'b0;
  logic       vsync = 1'b0;
  logic       hblank = 1'b1;
  logic       vblank = 1'b1;
  logic       blend_en = 1'b0;
  logic       custom_pal_en = 1'b0;
  logic       pal_wr = 1'b0;
  logic [3:0] pal_addr = 4'd0;
  logic [7:0] pal_din = 8'd0;
  logic [7:0] red, green, blue;
  logic       hsync_out, vsync_out, hblank_out, vblank_out;

  sv_frame_blender dut (
    .clk_sys       (clk_sys),
    .reset         (reset),
    .ce_pix        (ce_pix),
    .pixel         (pixel),
    .hsync         (hsync),
    .vsync         (vsync),
    .hblank        (hblank),
    .vblank        (vblank),
    .blend_en      (blend_en),
    .custom_pal_en (custom_pal_en),
    .pal_wr        (pal_wr),
    .pal_addr      (pal_addr),
    .pal_din       (pal_din),
    .red           (red),
    .green         (green),
    .blue          (blue),
    .hsync_out     (hsync_out),
    .vsync_out     (vsync_out),
    .hblank_out    (hblank_out),
    .vblank_out    (vblank_out)
  );

  always #5 clk_sys = ~clk_sys;

  int n_chk = 0;
  int n_pass = 0;
  bit chk_on = 1'b0;
  bit ce_rand = 1'b0;
  bit pal_rand = 1'b0;

  localparam int NPIX = 25600;

  // Reference model state: palettes as R,G,B byte lists, history as a plain array
  logic [7:0] def_pal [12] = '{8'h87, 8'hBA, 8'h6B, 8'h6B, 8'hA3, 8'h78,
                               8'h38, 8'h6B, 8'h82, 8'h38, 8'h40, 8'h52};
  logic [7:0] m_pal [12];
  logic [1:0] m_ram [32768];
  bit         m_known [32768];
  int         m_cnt;
  bit         m_ovf, m_seen, m_fv;
  logic [1:0] s1_cur, s1_prev;
  bit         s1_known;
  logic [3:0] s1_tim;
  int         e_col [3];
  bit         e_known;
  logic [3:0] e_tim;

  function automatic int pal_c(input logic [1:0] ent, input int ch);
    int idx;
    idx = int'(ent) * 3 + ch;
    return custom_pal_en ? int'(m_pal[idx]) : int'(def_pal[idx]);
  endfunction

  task automatic m_reset();
    m_cnt = 0; m_ovf = 0; m_seen = 0; m_fv = 0;
    m_pal = def_pal;
    s1_cur = 2'd0; s1_prev = 2'd0; s1_known = 1'b1; s1_tim = 4'b0011;
    e_col = '{0, 0, 0}; e_known = 1'b1; e_tim = 4'b0011;
  endtask

  task automatic m_step();
    for (int ch = 0; ch < 3; ch++) begin
      if (blend_en) e_col[ch] = (pal_c(s1_cur, ch) + pal_c(s1_prev, ch)) / 2;
      else          e_col[ch] = pal_c(s1_cur, ch);
    end
    e_known = !blend_en || s1_known;
    e_tim   = s1_tim;
    s1_cur = pixel; s1_prev = pixel; s1_known = 1'b1;
    s1_tim = {hsync, vsync, hblank, vblank};
    if (vsync) begin
      m_cnt = 0; m_ovf = 0;
      if (m_seen) m_fv = 1;
      m_seen = 0;
    end else if (!hblank && !vblank) begin
      m_seen = 1;
      if (!m_ovf) begin
        if (m_fv) begin
          s1_prev  = m_ram[m_cnt];
          s1_known = m_known[m_cnt];
        end
        m_ram[m_cnt] = pixel;
        m_known[m_cnt] = 1'b1;
        if (m_cnt == NPIX - 1) m_ovf = 1;
        else m_cnt++;
      end
    end
  endtask

  always @(posedge clk_sys or posedge reset) begin
    if (reset) m_reset();
    else begin
      if (ce_pix) m_step();
      if (pal_wr && pal_addr < 4'd12) m_pal[pal_addr] = pal_din;
    end
  end

  always @(negedge clk_sys) begin
    if (chk_on) begin : cmp
      bit ok;
      ok = ({hsync_out, vsync_out, hblank_out, vblank_out} === e_tim);
      if (e_known)
        ok = ok && (red === 8'(e_col[0])) && (green === 8'(e_col[1])) && (blue === 8'(e_col[2]));
      n_chk++;
      if (ok) n_pass++;
      else $display("FAIL pipe t=%0t got rgb=%02h%02h%02h tim=%b exp rgb=%02h%02h%02h tim=%b known=%0d",
                    $time, red, green, blue, {hsync_out, vsync_out, hblank_out, vblank_out},
                    8'(e_col[0]), 8'(e_col[1]), 8'(e_col[2]), e_tim, e_known);
    end
  end

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s got %h exp %h", name, got, exp);
  endtask

  task automatic check_lit(input string name, input logic [23:0] exp);
    @(posedge clk_sys);
    #1;
    chk({name, "_dut"}, {8'h0, red, green, blue}, {8'h0, exp});
    chk({name, "_model"}, {8'h0, 8'(e_col[0]), 8'(e_col[1]), 8'(e_col[2])}, {8'h0, exp});
  endtask

  task automatic pal_drive();
    if (pal_rand && $urandom_range(0, 15) == 0) begin
      pal_wr = 1'b1; pal_addr = 4'($urandom); pal_din = 8'($urandom);
    end else begin
      pal_wr = 1'b0;
    end
  endtask

  task automatic drive_pix(input logic [1:0] p, input logic hs, input logic vs,
                           input logic hb, input logic vb);
    if (ce_rand) begin
      while ($urandom_range(0, 2) == 0) begin
        @(negedge clk_sys);
        ce_pix = 1'b0; pixel = 2'($urandom); pal_drive();
      end
    end
    @(negedge clk_sys);
    ce_pix = 1'b1; pixel = p; hsync = hs; vsync = vs; hblank = hb; vblank = vb;
    pal_drive();
  endtask

  task automatic pal_write(input logic [3:0] a, input logic [7:0] d);
    @(negedge clk_sys);
    ce_pix = 1'b0; pal_wr = 1'b1; pal_addr = a; pal_din = d;
    @(negedge clk_sys);
    pal_wr = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge clk_sys);
    #2 ce_pix = 1'b0; reset = 1'b1;
    @(negedge clk_sys);
    @(negedge clk_sys);
    #2 reset = 1'b0;
  endtask

  task automatic run_frame(input int nl, input int w, input int extra, input bit rnd,
                           input logic [1:0] val, input int lit_line, input logic [23:0] lit_exp,
                           input string lit_name, input int rst_line, input int vsa_line);
    for (int i = 0; i < 2; i++) drive_pix(2'd0, 1'b0, 1'b1, 1'b1, 1'b1);
    for (int i = 0; i < 2; i++) drive_pix(2'd0, 1'b0, 1'b0, 1'b1, 1'b1);
    for (int l = 0; l < nl + int'(extra > 0); l++) begin
      int n;
      logic [1:0] pv;
      n = (l < nl) ? w : extra;
      if (l == rst_line) do_reset();
      if (l == vsa_line) drive_pix(val, 1'b0, 1'b1, 1'b0, 1'b0);
      for (int i = 0; i < n; i++) begin
        pv = rnd ? 2'($urandom_range(0, 3)) : ((l < nl) ? val : ~val);
        drive_pix(pv, 1'b0, 1'b0, 1'b0, 1'b0);
        if (l == lit_line && i == n / 2) check_lit(lit_name, lit_exp);
      end
      drive_pix(2'd0, 1'b0, 1'b0, 1'b1, 1'b0);
      drive_pix(2'd0, 1'b1, 1'b0, 1'b1, 1'b0);
      drive_pix(2'd0, 1'b0, 1'b0, 1'b1, 1'b0);
    end
  endtask

  initial begin
    repeat (3) @(negedge clk_sys);
    chk("rst_rgb", {8'h0, red, green, blue}, 32'h0);
    chk("rst_tim", {28'h0, hsync_out, vsync_out, hblank_out, vblank_out}, 32'h3);
    chk_on = 1'b1;
    #2 reset = 1'b0;

    blend_en = 1'b1;
    run_frame(4, 20, 0, 0, 2'd3, 1, 24'h384052, "first_frame", -1, -1);
    run_frame(4, 20, 0, 0, 2'd0, -1, 24'h0, "", -1, -1);
    run_frame(4, 20, 0, 0, 2'd3, 1, 24'h5F7D5E, "blend_b", -1, -1);
    blend_en = 1'b0;
    run_frame(4, 20, 0, 0, 2'd0, -1, 24'h0, "", -1, -1);
    run_frame(4, 20, 0, 0, 2'd3, 1, 24'h384052, "noblend_b", -1, -1);

    custom_pal_en = 1'b1;
    pal_write(4'd0, 8'hFF); pal_write(4'd1, 8'h00); pal_write(4'd2, 8'h00);
    run_frame(3, 20, 0, 0, 2'd0, 1, 24'hFF0000, "user_pal", -1, -1);
    pal_write(4'd13, 8'h55); pal_write(4'd12, 8'hAA); pal_write(4'd15, 8'h11);
    run_frame(3, 20, 0, 0, 2'd0, 1, 24'hFF0000, "pal_ignore", -1, -1);
    run_frame(3, 20, 0, 0, 2'd3, 1, 24'h384052, "user_default", -1, -1);

    ce_rand = 1'b1; pal_rand = 1'b1;
    for (int f = 0; f < 8; f++) begin
      blend_en = 1'($urandom); custom_pal_en = 1'($urandom);
      run_frame($urandom_range(3, 6), $urandom_range(8, 24), 0, 1, 2'd0, -1, 24'h0, "", -1, -1);
    end
    ce_rand = 1'b0; pal_rand = 1'b0; pal_wr = 1'b0;

    blend_en = 1'b1; custom_pal_en = 1'b0;
    run_frame(4, 20, 0, 0, 2'd0, -1, 24'h0, "", -1, -1);
    run_frame(4, 20, 0, 0, 2'd3, 2, 24'h384052, "after_reset", 1, -1);
    run_frame(4, 20, 0, 0, 2'd0, 1, 24'h5F7D5E, "post_reset_blend", -1, 2);

    run_frame(160, 160, 1, 0, 2'd1, -1, 24'h0, "", -1, -1);
    run_frame(160, 160, 0, 1, 2'd0, -1, 24'h0, "", -1, -1);

    repeat (4) @(negedge clk_sys);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
